// File: rtl/mem_access_unit.sv
// mem_access_unit: performs data-RAM loads and stores for the CPU using a
// req/ack handshake, and returns an aligned, sign- or zero-extended load
// result for writeback. busy stalls the CPU while an access is in flight.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               one-cycle request; mem_read/mem_write select load/store
//   size                00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   unsigned_ld         1 = zero-extend loads, 0 = sign-extend
//   addr, store_data    byte address and store value
//   busy, done          access in flight / one-cycle completion pulse
//   load_result         extended load data, held until the next successful load
//   misaligned, timeout fault flags, valid only with done
//   ram_*               word-aligned RAM request interface
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_result,
  output logic              misaligned,
  output logic              timeout,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;
  state_t state, state_next;

  logic              write_q;
  logic              unsigned_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic              fault_mis_q;
  logic              fault_to_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              illegal;
  logic              expired;
  logic [3:0]        place_be;
  logic [31:0]       place_wdata;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;

  always_comb begin
    accept  = start && (mem_read ^ mem_write);
    illegal = (size_q == 2'b11) ||
              (size_q == 2'b01 && addr_q[0]) ||
              (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    expired = (cnt == CNT_LAST);
  end

  // Store lane placement: data is replicated across lanes, byte enables pick
  // which lane the RAM actually writes.
  always_comb begin
    place_be    = 4'b1111;
    place_wdata = sdata_q;
    if (write_q) begin
      case (size_q)
        2'b00: begin
          place_be    = 4'b0001 << addr_q[1:0];
          place_wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          place_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          place_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          place_be    = 4'b1111;
          place_wdata = sdata_q;
        end
      endcase
    end else begin
      place_wdata = '0;
    end
  end

  // Load extraction from the little-endian lane.
  always_comb begin
    lane_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = unsigned_q ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      fault_mis_q <= 1'b0;
      fault_to_q  <= 1'b0;
      cnt         <= '0;
      load_result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q     <= mem_write;
            unsigned_q  <= unsigned_ld;
            size_q      <= size;
            addr_q      <= addr;
            sdata_q     <= store_data;
            fault_mis_q <= 1'b0;
            fault_to_q  <= 1'b0;
          end
        end
        CHECK: begin
          cnt         <= '0;
          fault_mis_q <= illegal;
        end
        REQ: begin
          // An ack on the expiry cycle wins over the timeout.
          if (ram_ack) begin
            if (!write_q) load_result <= load_ext;
          end else if (expired) begin
            fault_to_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    timeout    = 1'b0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_be     = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = illegal ? DONE : REQ;
      end
      REQ: begin
        busy      = 1'b1;
        ram_req   = 1'b1;
        ram_we    = write_q;
        ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        ram_wdata = place_wdata;
        ram_be    = place_be;
        if (ram_ack || expired) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        misaligned = fault_mis_q;
        timeout    = fault_to_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized accesses
// checked against a behavioural model of lane placement and load extension.
module tb_mem_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_result;
  logic        misaligned;
  logic        timeout;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_load = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_result(load_result), .misaligned(misaligned), .timeout(timeout),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_ack(ram_ack),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && off % 2 != 0) return 1'b1;
    if (sz == 2'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [1:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    if (!wr || sz == 2'd2) return 4'hF;
    if (sz == 2'd0) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                              input logic [31:0] a, input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] v;
    if (sz == 2'd2) return rd;
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = (rd >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Runs one access starting in the next cycle; returns during the done cycle.
  // ack_delay = -1 means the RAM never acknowledges.
  task automatic run_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] sd, input int ack_delay,
                            input logic [31:0] rdat, input bit poke);
    bit ill;
    bit acked;
    int w;
    ill = is_illegal(sz, a);
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_flags", {misaligned, timeout}, 0);
    start = 1'b1; mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns;
    addr = a; store_data = sd;
    @(posedge clk); #1;
    start = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    size = 2'($urandom); unsigned_ld = 1'($urandom); addr = $urandom; store_data = $urandom;
    check("chk_busy", busy, 1);
    check("chk_noreq", ram_req, 0);
    if (ill) begin
      @(posedge clk); #1;
      check("mis_done", done, 1);
      check("mis_flag", misaligned, 1);
      check("mis_timeout", timeout, 0);
      check("mis_noreq", ram_req, 0);
      check("mis_busy", busy, 0);
      check("mis_load", load_result, exp_load);
    end else begin
      acked = 1'b0;
      w = 0;
      while (!acked && w < int'(TO)) begin
        @(posedge clk); #1;
        ram_ack = 1'b0; ram_rdata = $urandom;
        start = 1'b0;
        check("req_req", ram_req, 1);
        check("req_busy", busy, 1);
        check("req_done", done, 0);
        check("req_addr", ram_addr, a & 32'hFFFF_FFFC);
        check("req_we", ram_we, wr);
        check("req_be", ram_be, model_be(wr, sz, a));
        if (wr) check("req_wdata", ram_wdata, model_wdata(sz, sd));
        if (w == ack_delay) begin
          ram_ack = 1'b1; ram_rdata = rdat; acked = 1'b1;
        end
        if (poke && w == 3) begin
          start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        end
        w++;
      end
      @(posedge clk); #1;
      ram_ack = 1'b0; start = 1'b0; ram_rdata = $urandom;
      if (acked && rd) exp_load = model_load(sz, uns, a, rdat);
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_noreq", ram_req, 0);
      check("end_mis", misaligned, 0);
      check("end_timeout", timeout, !acked);
      check("end_load", load_result, exp_load);
    end
  endtask

  initial begin
    bit rd;
    logic [1:0] sz;
    logic [31:0] a;
    int r, dly;

    reset = 1'b1; start = 0; mem_read = 0; mem_write = 0; size = 0; unsigned_ld = 0;
    addr = 0; store_data = 0; ram_ack = 0; ram_rdata = 0;
    #12;
    check("rst_outs", {busy, done, misaligned, timeout, ram_req, ram_we, ram_be}, 0);
    check("rst_load", load_result, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    reset = 1'b0;

    // Word load with zero-wait RAM.
    run_access(1, 0, 2'd2, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0);
    // Signed / unsigned byte load at lane 3.
    run_access(1, 0, 2'd0, 0, 32'h103, 0, 1, 32'h80FFFF12, 0);
    check("sbyte_val", load_result, 32'hFFFFFF80);
    run_access(1, 0, 2'd0, 1, 32'h103, 0, 2, 32'h80FFFF12, 0);
    check("ubyte_val", load_result, 32'h00000080);
    // Halfword store with a 3-cycle ack delay.
    run_access(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 3, 0, 0);
    // Faulting requests.
    run_access(1, 0, 2'd2, 0, 32'h101, 0, 0, 32'h11111111, 0);
    run_access(0, 1, 2'd3, 0, 32'h100, 32'h55, 0, 0, 0);
    run_access(1, 0, 2'd1, 1, 32'h203, 0, 0, 32'h22222222, 0);
    // Timeout with an ignored start during the wait, then ack on the last cycle.
    run_access(1, 0, 2'd2, 0, 32'h300, 0, -1, 32'h33333333, 1);
    run_access(1, 0, 2'd1, 0, 32'h302, 0, int'(TO) - 1, 32'h8001_7FFF, 0);
    check("lastack_val", load_result, 32'hFFFF8001);

    // Ack while idle and malformed starts are ignored.
    @(posedge clk); #1;
    ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    check("idleack_busy", busy, 0);
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    @(posedge clk); #1;
    check("both_busy", busy, 0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("none_busy", busy, 0);
    check("none_done", done, 0);
    check("ignored_load", load_result, exp_load);

    // Asynchronous reset while in REQ.
    @(posedge clk); #1;
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("prerst_req", ram_req, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst_req", ram_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_load", load_result, 0);
    exp_load = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    run_access(1, 0, 2'd1, 0, 32'h46, 0, 1, 32'hA5A5_0000, 0);

    // Randomized accesses.
    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom);
      r = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
      end
      r = int'($urandom_range(0, 19));
      dly = (r == 0) ? -1 : (r == 1) ? int'(TO) - 1 : int'($urandom_range(0, 4));
      run_access(rd, !rd, sz, 1'($urandom), a, $urandom, dly, $urandom, 0);
    end

    @(posedge clk); #1;
    check("final_done", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
